// File: rtl/clk_div_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor family.
package clk_div_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    function automatic logic is_match(int cnt, int hcnt, int exp_div, int exp_high);
        return (cnt == exp_div) && (hcnt == exp_high);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a divided-clock source and its monitor.
interface clk_div_monitor_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             stall;

    // source side: drives the signal under test, observes the verdict
    modport master (
        output sig_in,
        input  period, high_time, meas_valid, locked, err, stall
    );

    // monitor side
    modport slave (
        input  sig_in,
        output period, high_time, meas_valid, locked, err, stall
    );

endinterface

// File: rtl/clk_div_monitor_edge_detect_rise.sv
// Rising-edge detector for a signal already synchronous to clk.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic s_q;

    always_ff @(posedge clk) begin
        if (rst) s_q <= 1'b0;
        else     s_q <= d;
    end

    assign rise = ~s_q & d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock and tracks lock against an expected ratio.
//   state | meaning
//   IDLE  | waiting for a first rising edge to start counting
//   MEAS  | counting between rising edges, one measurement per edge
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_DIV    = 2,
    parameter int EXP_HIGH   = 1,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    clk_div_monitor_if.slave   bus
);

    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0]  MC_LIM  = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic             rise;
    logic             match;

    edge_detect_rise u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .rise (rise)
    );

    assign match = is_match(int'(cnt_q), int'(hcnt_q), EXP_DIV, EXP_HIGH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            mcnt_q   <= '0;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            mcnt_q   <= mcnt_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        mcnt_d   = mcnt_q;
        mv_d     = 1'b0;
        locked_d = locked_q;
        err_d    = 1'b0;
        stall_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d   = ONE;
                    hcnt_d  = ONE;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                // an edge landing on the timeout cycle still counts as a measurement
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    mv_d     = 1'b1;
                    cnt_d    = ONE;
                    hcnt_d   = ONE;
                    if (match) begin
                        if (mcnt_q != MC_LIM) mcnt_d = mcnt_q + MC_W'(1);
                        if (int'(mcnt_q) + 1 >= LOCK_COUNT) locked_d = 1'b1;
                    end else begin
                        mcnt_d   = '0;
                        locked_d = 1'b0;
                        err_d    = locked_q;
                    end
                end else if (cnt_q == TMO) begin
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                    mcnt_d   = '0;
                    state_d  = IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
                    if (bus.sig_in && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = mv_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.stall      = stall_q;

endmodule
